vga_ps2_controller: RTL and testbench
=====================================

Name: vga_ps2_controller

Overview:
Board-level controller for a 50 MHz FPGA board. It receives scan codes from a PS/2 keyboard and moves a 32x32 coloured box across a 640x480@60 Hz VGA screen. Two push buttons change the box colour and recentre the box. Six LEDs show the last accepted scan code.

Parameters:
CLK_HZ, 50_000_000, system clock frequency.
BOX, 32, box edge length in pixels.
STEP, 8, pixels moved per key make code.
PS2_TIMEOUT, 50_000, clocks without a PS/2 falling edge before a partial frame is discarded.
DEBOUNCE, 1_000_000, clocks a button level must stay stable before it is accepted.

Ports:
CLK_50M  in  1  system clock, 50 MHz.
RST_N  in  1  synchronous reset, active-low.
BTN_NORTH  in  1  raw push button, active-high; cycles the box colour.
BTN_SOUTH  in  1  raw push button, active-high; recentres the box.
PS2_CLK1  inout  1  PS/2 clock; only ever driven high-Z (receive only).
PS2_DATA1  inout  1  PS/2 data; only ever driven high-Z.
LED  out  6  last valid make code, bits [5:0].
VGA_R/VGA_G/VGA_B  out  4 each  pixel colour.
VGA_HSYNC  out  1  horizontal sync, active-low.
VGA_VSYNC  out  1  vertical sync, active-low.

Behaviour:
Clocking and reset
- One clock domain: CLK_50M.
- Reset is synchronous, active-low, on RST_N. Everything below is sampled on the rising edge of CLK_50M.
- Reset state: counters 0, pix_en 0, box at (304,224), colour index 0, LED=0, RGB=0, HSYNC=1, VSYNC=1, PS/2 receiver idle.

VGA timing
- pix_en toggles every clock (25 MHz).
- h/v counters advance only when pix_en=1.
- h counts 0..799: visible 0..639, sync 656..751.
- v counts 0..524 and increments when h wraps 799→0: visible 0..479, sync 490..491.
- Outputs are registered, one clock after the counter state.
  - HSYNC=0 while h is in 656..751.
  - VSYNC=0 while v is in 490..491.
  - RGB=0 outside the visible area.
  - Inside the visible area: box colour if x≤h<x+BOX and y≤v<y+BOX, otherwise 0.
- Palette by colour index: 0 → FFF, 1 → F00, 2 → 0F0, 3 → 00F. The index wraps 3→0.

PS/2 receiver
- PS2_CLK1 and PS2_DATA1 each pass through a 2-FF synchroniser.
- A falling edge of the synchronised clock samples one data bit.
- Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
- A frame is valid only if start, parity and stop are all correct. Invalid frames are dropped silently.
- A 1-clock code_valid pulse with the byte is produced 1 clock after the stop bit is sampled.
- If PS2_TIMEOUT clocks pass without a falling edge mid-frame, the bit counter resets.

Key decoding
- Byte F0 sets a break flag. The next byte clears the flag and is otherwise ignored.
- Byte E0 is ignored and does not clear the break flag.
- Any other make byte:
  - Updates LED with byte[5:0].
  - 1D (W): y -= STEP.
  - 1B (S): y += STEP.
  - 1C (A): x -= STEP.
  - 23 (D): x += STEP.
- Moves clamp to x in 0..640-BOX and y in 0..480-BOX. There is no wrap-around.
- Position updates apply immediately; mid-frame tearing is acceptable.

Buttons
- Each button: 2-FF synchroniser, then a DEBOUNCE counter.
- Action fires on the rising edge of the debounced level.
- BTN_NORTH edge: colour index +1.
- BTN_SOUTH edge: box returns to (304,224).
- If a recentre and a key move happen in the same cycle, the recentre wins.

Reset mid-operation
- A reset during a frame drops any partial PS/2 frame and returns every block to the reset state.

Decomposition:
- Shared package holds:
  - VGA timing constants (visible, front, sync and total counts for h and v).
  - Scan codes F0, E0, 1D, 1B, 1C, 23.
  - The palette array.
- Sub-module ps2_rx holds the PS/2 synchroniser, framing, parity check and timeout. It outputs an 8-bit code and a code_valid pulse.
- VGA timing, key decoding and button handling stay in the top module.

Test Plan:
- Reset: hold RST_N=0 for 4 clocks → LED=0, RGB=0, HSYNC=1, VSYNC=1.
- VGA timing: free-run after reset → HSYNC period 1600 clocks with 192 clocks low; VSYNC period 840000 clocks with 3200 clocks low; RGB=0 throughout blanking.
- Valid key: send PS/2 frame 0x23 (odd parity, 12.5 kHz bit clock) → LED=6'b100011; box left edge moves from h=304 to 312, checked on visible line 224.
- Break sequence and bad frame: send F0 then 23 → no move and LED unchanged. Send 0x1C with wrong parity → no move.
- Clamp: send A (1C) 40 times → x=0 and stays 0. Then BTN_SOUTH held high past DEBOUNCE → box back at (304,224).
- Colour cycling: press BTN_NORTH 5 times → index 1 after the 5th press; box pixels read R=F, G=0, B=0. A glitch shorter than DEBOUNCE → no change.

Source files
------------

// File: rtl/vga_ps2_controller_pkg.sv
// vga_ps2_controller_pkg: VGA timing, scan codes and palette shared by the controller
package vga_ps2_controller_pkg;
    localparam int H_VIS   = 640;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_TOTAL = 800;
    localparam int V_VIS   = 480;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_TOTAL = 525;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // index 0 is the last element: white, red, green, blue
    localparam logic [3:0][11:0] PALETTE = {12'h00F, 12'h0F0, 12'hF00, 12'hFFF};
endpackage

// File: rtl/vga_ps2_controller_ps2_rx.sv
// vga_ps2_controller_ps2_rx: receive-only PS/2 deserialiser with framing, odd-parity check and stall timeout
module vga_ps2_controller_ps2_rx #(
    parameter int TIMEOUT = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    clk_sr;
    logic [1:0]    dat_sr;
    logic [10:0]   frame;
    logic [3:0]    bit_cnt;
    logic          done;
    logic [TW-1:0] idle;
    logic          fall;

    // clk_sr[1] is the synchronised clock, clk_sr[2] its previous value
    assign fall = clk_sr[2] & ~clk_sr[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sr     <= 3'b111;
            dat_sr     <= 2'b11;
            frame      <= '0;
            bit_cnt    <= '0;
            done       <= 1'b0;
            idle       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            clk_sr     <= {clk_sr[1:0], ps2_clk};
            dat_sr     <= {dat_sr[0], ps2_data};
            done       <= fall && bit_cnt == 4'd10;
            code_valid <= done && !frame[0] && frame[10] && ^frame[9:1];
            if (done)
                code <= frame[8:1];
            if (fall) begin
                frame   <= {dat_sr[1], frame[10:1]};
                bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                idle    <= '0;
            end else if (bit_cnt != 4'd0) begin
                idle <= idle + TW'(1);
                if (idle == TW'(TIMEOUT - 1)) begin
                    bit_cnt <= '0;
                    idle    <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/vga_ps2_controller.sv
// vga_ps2_controller: PS/2 keyboard steers a coloured box on a 640x480@60 VGA screen
module vga_ps2_controller
    import vga_ps2_controller_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BOX         = 32,
    parameter int STEP        = 8,
    parameter int PS2_TIMEOUT = 50_000,
    parameter int DEBOUNCE    = 1_000_000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       BTN_NORTH,
    input  logic       BTN_SOUTH,
    inout  wire        PS2_CLK1,
    inout  wire        PS2_DATA1,
    output logic [5:0] LED,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC
);
    localparam int PIX_DIV = CLK_HZ / 25_000_000;
    localparam int DBW     = $clog2(DEBOUNCE + 1);
    localparam int X0      = (H_VIS - BOX) / 2;
    localparam int Y0      = (V_VIS - BOX) / 2;
    localparam int X_MAX   = H_VIS - BOX;
    localparam int Y_MAX   = V_VIS - BOX;

    assign PS2_CLK1  = 1'bz;
    assign PS2_DATA1 = 1'bz;

    logic [7:0] div_cnt;
    logic       pix_en;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] box_x, box_y;
    logic [1:0] colour;
    logic       brk;
    logic [7:0] code;
    logic       code_valid;
    logic       make;
    logic [9:0] nx, ny;
    logic       in_h_sync, in_v_sync, visible, in_box;
    logic [1:0] btn_raw, btn_rise;

    vga_ps2_controller_ps2_rx #(.TIMEOUT(PS2_TIMEOUT)) u_rx (
        .clk       (CLK_50M),
        .rst_n     (RST_N),
        .ps2_clk   (PS2_CLK1),
        .ps2_data  (PS2_DATA1),
        .code      (code),
        .code_valid(code_valid)
    );

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= (div_cnt == 8'(PIX_DIV - 1)) ? 8'd0 : div_cnt + 8'd1;
            pix_en  <= div_cnt == 8'(PIX_DIV - 2);
            if (pix_en) begin
                h_cnt <= (h_cnt == 10'(H_TOTAL - 1)) ? 10'd0 : h_cnt + 10'd1;
                if (h_cnt == 10'(H_TOTAL - 1))
                    v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        in_h_sync = h_cnt >= 10'(H_VIS + H_FRONT) && h_cnt < 10'(H_VIS + H_FRONT + H_SYNC);
        in_v_sync = v_cnt >= 10'(V_VIS + V_FRONT) && v_cnt < 10'(V_VIS + V_FRONT + V_SYNC);
        visible   = h_cnt < 10'(H_VIS) && v_cnt < 10'(V_VIS);
        in_box    = h_cnt >= box_x && h_cnt < box_x + 10'(BOX) &&
                    v_cnt >= box_y && v_cnt < box_y + 10'(BOX);
    end

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            VGA_HSYNC                <= 1'b1;
            VGA_VSYNC                <= 1'b1;
            {VGA_R, VGA_G, VGA_B}    <= 12'h000;
        end else begin
            VGA_HSYNC                <= !in_h_sync;
            VGA_VSYNC                <= !in_v_sync;
            {VGA_R, VGA_G, VGA_B}    <= (visible && in_box) ? PALETTE[colour] : 12'h000;
        end
    end

    // button 0 = north (colour), button 1 = south (recentre)
    assign btn_raw = {BTN_SOUTH, BTN_NORTH};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic           meta, sync, level;
        logic [DBW-1:0] cnt;
        always_ff @(posedge CLK_50M) begin
            if (!RST_N) begin
                meta  <= 1'b0;
                sync  <= 1'b0;
                level <= 1'b0;
                cnt   <= '0;
            end else begin
                meta <= btn_raw[i];
                sync <= meta;
                cnt  <= (sync != level && cnt != DBW'(DEBOUNCE - 1)) ? cnt + DBW'(1) : '0;
                if (sync != level && cnt == DBW'(DEBOUNCE - 1))
                    level <= sync;
            end
        end
        assign btn_rise[i] = sync && !level && cnt == DBW'(DEBOUNCE - 1);
    end

    always_comb begin
        make = code_valid && code != SC_BREAK && code != SC_EXT && !brk;
        nx   = (code == SC_A) ? ((box_x >= 10'(STEP)) ? box_x - 10'(STEP) : 10'd0) :
               (code == SC_D) ? ((box_x + 10'(STEP) <= 10'(X_MAX)) ? box_x + 10'(STEP) : 10'(X_MAX)) :
               box_x;
        ny   = (code == SC_W) ? ((box_y >= 10'(STEP)) ? box_y - 10'(STEP) : 10'd0) :
               (code == SC_S) ? ((box_y + 10'(STEP) <= 10'(Y_MAX)) ? box_y + 10'(STEP) : 10'(Y_MAX)) :
               box_y;
    end

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            brk    <= 1'b0;
            LED    <= '0;
            box_x  <= 10'(X0);
            box_y  <= 10'(Y0);
            colour <= '0;
        end else begin
            if (btn_rise[0])
                colour <= colour + 2'd1;
            // E0 prefixes leave a pending break in place
            if (code_valid && code == SC_BREAK)
                brk <= 1'b1;
            else if (code_valid && code != SC_EXT)
                brk <= 1'b0;
            if (make)
                LED <= code[5:0];
            if (btn_rise[1]) begin
                box_x <= 10'(X0);
                box_y <= 10'(Y0);
            end else if (make) begin
                box_x <= nx;
                box_y <= ny;
            end
        end
    end
endmodule

// File: tb/tb_vga_ps2_controller.sv
// tb_vga_ps2_controller: vectors, corner sequences and randomized keys against a behavioural screen model
module tb_vga_ps2_controller;
    localparam int DEB  = 16;
    localparam int TMO  = 200;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b0, btn_s = 1'b0;
    logic       ps2_clk_d = 1'b1, ps2_dat_d = 1'b1;
    wire        ps2_clk_w, ps2_dat_w;
    logic [5:0] led;
    logic [3:0] r, g, b;
    logic       hs, vs;

    assign ps2_clk_w = ps2_clk_d;
    assign ps2_dat_w = ps2_dat_d;

    vga_ps2_controller #(.PS2_TIMEOUT(TMO), .DEBOUNCE(DEB)) dut (
        .CLK_50M(clk), .RST_N(rst_n), .BTN_NORTH(btn_n), .BTN_SOUTH(btn_s),
        .PS2_CLK1(ps2_clk_w), .PS2_DATA1(ps2_dat_w), .LED(led),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HSYNC(hs), .VGA_VSYNC(vs)
    );

    always #10 clk = ~clk;

    int tests = 0, failed = 0;
    int n = 0;
    int hv_err = 0, rgb_err = 0;
    bit rgb_chk = 1'b0;
    int mx = 304, my = 224, mc = 0, m_led = 0;
    bit m_brk = 1'b0;
    logic [11:0] pal [4] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F};

    typedef struct {
        logic [7:0] code;
        bit         bad;
        int         led;
        int         x;
        int         y;
    } vec_t;
    vec_t vecs [11];

    always @(posedge clk) n <= rst_n ? n + 1 : 0;

    // the screen is a pure function of the pixel index since reset and the model box
    int sp, sh, sv;
    logic [11:0] exp_rgb;
    always @(negedge clk) if (n >= 1) begin
        sp = (n - 1) / 2;
        sh = sp % 800;
        sv = (sp / 800) % 525;
        if (hs != !(sh >= 656 && sh < 752) || vs != !(sv >= 490 && sv < 492))
            hv_err++;
        exp_rgb = (sh < 640 && sv < 480 && sh >= mx && sh < mx + 32 && sv >= my && sv < my + 32) ? pal[mc] : 12'h000;
        if (rgb_chk && {r, g, b} != exp_rgb)
            rgb_err++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_key(input logic [7:0] c);
        if (c == 8'hF0) m_brk = 1'b1;
        else if (c == 8'hE0) m_brk = m_brk;
        else if (m_brk) m_brk = 1'b0;
        else begin
            m_led = int'(c[5:0]);
            if (c == 8'h1D) my = (my - 8 < 0) ? 0 : my - 8;
            if (c == 8'h1B) my = (my + 8 > 448) ? 448 : my + 8;
            if (c == 8'h1C) mx = (mx - 8 < 0) ? 0 : mx - 8;
            if (c == 8'h23) mx = (mx + 8 > 608) ? 608 : mx + 8;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nb);
        for (int k = 0; k < nb; k++) begin
            ps2_dat_d = bits[k];
            repeat (HALF) @(negedge clk);
            ps2_clk_d = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk_d = 1'b1;
        end
        ps2_dat_d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad);
        rgb_chk = 1'b0;
        send_bits({1'b1, (~^c) ^ bad, c, 1'b0}, 11);
        repeat (20) @(negedge clk);
        if (!bad) model_key(c);
        rgb_chk = 1'b1;
    endtask

    task automatic press(input int which, input int hold);
        rgb_chk = 1'b0;
        if (which == 0) btn_n = 1'b1; else btn_s = 1'b1;
        repeat (hold) @(negedge clk);
        btn_n = 1'b0;
        btn_s = 1'b0;
        repeat (40) @(negedge clk);
        if (hold >= DEB + 4) begin
            if (which == 0) mc = (mc + 1) % 4;
            else begin mx = 304; my = 224; end
        end
        rgb_chk = 1'b1;
    endtask

    task automatic check_pos(input string name, input int led_e, input int x_e, input int y_e);
        check({name, "_led"}, int'(led), led_e);
        check({name, "_x"}, int'(dut.box_x), x_e);
        check({name, "_y"}, int'(dut.box_y), y_e);
    endtask

    task automatic pixel_check(input string name, input int hx, input logic [11:0 ] exp);
        int p;
        bit found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(negedge clk);
            p = (n - 1) / 2;
            if (p % 800 == hx && (p / 800) % 525 < 32) found = 1'b1;
        end
        check(name, found ? int'({r, g, b}) : -1, int'(exp));
    endtask

    task automatic measure_hsync();
        int t0 = -1, t1 = -1, t2 = -1;
        logic prev, cur;
        @(negedge clk);
        prev = hs;
        for (int k = 0; k < 4000 && t2 < 0; k++) begin
            @(negedge clk);
            cur = hs;
            if (prev && !cur) begin
                if (t0 < 0) t0 = k; else t2 = k;
            end
            if (!prev && cur && t0 >= 0 && t1 < 0) t1 = k;
            prev = cur;
        end
        check("hsync_period", t2 - t0, 1600);
        check("hsync_low", t1 - t0, 192);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h23, 1'b0, 'h23, 312, 224};
        vecs[1]  = '{8'hF0, 1'b0, 'h23, 312, 224};
        vecs[2]  = '{8'h23, 1'b0, 'h23, 312, 224};
        vecs[3]  = '{8'h1C, 1'b1, 'h23, 312, 224};
        vecs[4]  = '{8'hE0, 1'b0, 'h23, 312, 224};
        vecs[5]  = '{8'h1C, 1'b0, 'h1C, 304, 224};
        vecs[6]  = '{8'hF0, 1'b0, 'h1C, 304, 224};
        vecs[7]  = '{8'hE0, 1'b0, 'h1C, 304, 224};
        vecs[8]  = '{8'h1B, 1'b0, 'h1C, 304, 224};
        vecs[9]  = '{8'h1B, 1'b0, 'h1B, 304, 232};
        vecs[10] = '{8'h15, 1'b0, 'h15, 304, 232};

        repeat (4) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_rgb", int'({r, g, b}), 0);
        check("rst_hsync", int'(hs), 1);
        check("rst_vsync", int'(vs), 1);
        rst_n = 1'b1;
        rgb_chk = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].code, vecs[i].bad);
            check_pos($sformatf("vec%0d", i), vecs[i].led, vecs[i].x, vecs[i].y);
        end

        repeat (28) send_frame(8'h1D, 1'b0);
        check("w28_y", int'(dut.box_y), 8);
        send_frame(8'h1D, 1'b0);
        check("w29_y", int'(dut.box_y), 0);
        send_frame(8'h1D, 1'b0);
        check("w_clamp_y", int'(dut.box_y), 0);
        repeat (40) send_frame(8'h1C, 1'b0);
        check_pos("a_clamp", 'h1C, 0, 0);

        repeat (5) press(0, 40);
        press(0, 5);
        pixel_check("pix_h0_red", 0, 12'hF00);
        pixel_check("pix_h31_red", 31, 12'hF00);
        pixel_check("pix_h32_off", 32, 12'h000);

        press(1, 5);
        check("south_glitch_x", int'(dut.box_x), 0);
        press(1, 40);
        check_pos("recentre", 'h1C, 304, 224);

        repeat (37) send_frame(8'h23, 1'b0);
        check("d37_x", int'(dut.box_x), 600);
        repeat (5) send_frame(8'h23, 1'b0);
        check("d_clamp_x", int'(dut.box_x), 608);
        repeat (32) send_frame(8'h1B, 1'b0);
        check("s_clamp_y", int'(dut.box_y), 448);

        measure_hsync();

        for (int i = 0; i < 60; i++) begin
            logic [7:0] c;
            int sel = $urandom_range(0, 11);
            case (sel)
                0, 1: c = 8'h1D;
                2, 3: c = 8'h1B;
                4, 5: c = 8'h1C;
                6, 7: c = 8'h23;
                8:    c = 8'hF0;
                9:    c = 8'hE0;
                default: c = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 7) == 0) press(0, ($urandom_range(0, 1) == 1) ? 40 : 5);
            send_frame(c, $urandom_range(0, 7) == 0);
            check_pos($sformatf("rnd%0d", i), m_led, mx, my);
        end

        if (m_brk) send_frame(8'h15, 1'b0);
        send_bits(11'h2A5, 5);
        repeat (TMO + 100) @(negedge clk);
        send_frame(8'h24, 1'b0);
        check("timeout_led", int'(led), 'h24);

        rgb_chk = 1'b0;
        send_bits(11'h0F0, 4);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_led", int'(led), 0);
        check("midrst_hsync", int'(hs), 1);
        check("midrst_rgb", int'({r, g, b}), 0);
        rst_n = 1'b1;
        mx = 304; my = 224; mc = 0; m_led = 0; m_brk = 1'b0;
        rgb_chk = 1'b1;
        check_pos("midrst_box", 0, 304, 224);
        send_frame(8'h1D, 1'b0);
        check_pos("after_rst_key", 'h1D, 304, 216);

        repeat (2000) @(negedge clk);
        check("sync_stream_errors", hv_err, 0);
        check("rgb_stream_errors", rgb_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
